// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: steps the constant/function/accumulator selects of the MAC
// datapath through a run of n_eff terms. It handles a start/done handshake,
// a datapath drain delay, abort, and an optional automatic restart.
module mac_seq_ctrl #(
  parameter int N_TERMS  = 5,
  parameter int CONST_W  = 3,
  parameter int N_FUN    = 3,
  parameter int FUN_W    = 2,
  parameter int PIPE_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               cont_mode,
  input  logic [CONST_W-1:0] n_terms,
  output logic [CONST_W-1:0] sel_const,
  output logic [FUN_W-1:0]   sel_fun,
  output logic               sel_acum,
  output logic               clr_acum,
  output logic               busy,
  output logic               done,
  output logic               Band_Listo
);

  // Drain counter width; kept at least 1 bit so that PIPE_LAT = 0 still elaborates.
  localparam int DW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [CONST_W-1:0] k, k_nx;
  logic [CONST_W-1:0] n_eff, n_eff_nx;
  logic [DW-1:0]      drain, drain_nx;
  logic               band, band_nx;

  // A requested count of 0, or one above N_TERMS, selects the full N_TERMS run.
  function automatic logic [CONST_W-1:0] clamp_terms(input logic [CONST_W-1:0] n);
    if (n == '0 || n > CONST_W'(N_TERMS))
      clamp_terms = CONST_W'(N_TERMS);
    else
      clamp_terms = n;
  endfunction

  // The function mux is cycled modulo N_FUN with the term index.
  function automatic logic [FUN_W-1:0] fun_of(input logic [CONST_W-1:0] kk);
    int m;
    m = int'(kk) % N_FUN;
    fun_of = FUN_W'(m);
  endfunction

  // State and counter registers; asynchronous reset returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      n_eff <= '0;
      drain <= '0;
      band  <= 1'b0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
      n_eff <= n_eff_nx;
      drain <= drain_nx;
      band  <= band_nx;
    end
  end

  // Next-state and counter update logic; abort overrides everything outside IDLE.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    n_eff_nx = n_eff;
    drain_nx = drain;
    band_nx  = band;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nx = CLEAR;
          n_eff_nx = clamp_terms(n_terms);
          band_nx  = 1'b0;
        end
      end
      CLEAR: begin
        state_nx = RUN;
        k_nx     = CONST_W'(1);
      end
      RUN: begin
        if (k == n_eff) begin
          k_nx = '0;
          if (PIPE_LAT == 0) begin
            state_nx = DONE;
            band_nx  = 1'b1;
          end else begin
            state_nx = DRAIN;
            drain_nx = DW'(1);
          end
        end else begin
          k_nx = k + CONST_W'(1);
        end
      end
      DRAIN: begin
        if (drain == DW'(PIPE_LAT)) begin
          state_nx = DONE;
          drain_nx = '0;
          band_nx  = 1'b1;
        end else begin
          drain_nx = drain + DW'(1);
        end
      end
      DONE: begin
        if (cont_mode) begin
          state_nx = CLEAR;
          n_eff_nx = clamp_terms(n_terms);
          band_nx  = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        k_nx     = '0;
        drain_nx = '0;
      end
    endcase
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      k_nx     = '0;
      drain_nx = '0;
      band_nx  = 1'b0;
    end
  end

  // Moore output decode from the registered state and term index.
  always_comb begin
    sel_const  = '0;
    sel_fun    = '0;
    sel_acum   = 1'b0;
    clr_acum   = 1'b0;
    busy       = (state != IDLE);
    done       = (state == DONE);
    Band_Listo = band;
    case (state)
      CLEAR: clr_acum = 1'b1;
      RUN: begin
        sel_const = k;
        sel_fun   = fun_of(k);
        sel_acum  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed and randomized stimulus for mac_seq_ctrl, checked
// every cycle against a run-schedule model.
module tb_mac_seq_ctrl;

  localparam int N_TERMS  = 5;
  localparam int CONST_W  = 3;
  localparam int N_FUN    = 3;
  localparam int FUN_W    = 2;
  localparam int PIPE_LAT = 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, abort, cont_mode;
  logic [CONST_W-1:0] n_terms;
  logic [CONST_W-1:0] sel_const;
  logic [FUN_W-1:0]   sel_fun;
  logic               sel_acum, clr_acum, busy, done, Band_Listo;

  mac_seq_ctrl #(
    .N_TERMS (N_TERMS),
    .CONST_W (CONST_W),
    .N_FUN   (N_FUN),
    .FUN_W   (FUN_W),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cont_mode (cont_mode),
    .n_terms   (n_terms),
    .sel_const (sel_const),
    .sel_fun   (sel_fun),
    .sel_acum  (sel_acum),
    .clr_acum  (clr_acum),
    .busy      (busy),
    .done      (done),
    .Band_Listo(Band_Listo)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: position t within a run (1 = clear cycle), the run's
  // term count, and the result-valid flag.
  bit m_act;
  int m_t;
  int m_n;
  bit m_band;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int nt);
    return (nt == 0 || nt > N_TERMS) ? N_TERMS : nt;
  endfunction

  function automatic int run_len();
    return m_n + PIPE_LAT + 2;
  endfunction

  // Packed as {sel_const, sel_fun, sel_acum, clr_acum, busy, done, Band_Listo}.
  function automatic logic [31:0] exp_vec();
    int  sc, sf;
    bit  run, clr, dn;
    run = m_act && m_t >= 2 && m_t <= m_n + 1;
    clr = m_act && m_t == 1;
    dn  = m_act && m_t == run_len();
    sc  = run ? m_t - 1 : 0;
    sf  = run ? (m_t - 1) % N_FUN : 0;
    return {22'd0, sc[2:0], sf[1:0], run, clr, m_act, dn, m_band};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {22'd0, sel_const, sel_fun, sel_acum, clr_acum, busy, done, Band_Listo};
  endfunction

  task automatic model_reset();
    m_act = 0; m_t = 0; m_n = 0; m_band = 0;
  endtask

  task automatic model_step(input bit s, input bit a, input bit c, input int nt);
    if (!m_act) begin
      if (s && !a) begin
        m_act = 1; m_t = 1; m_n = clamp(nt); m_band = 0;
      end
    end else if (a) begin
      m_act = 0; m_t = 0; m_band = 0;
    end else if (m_t == run_len()) begin
      if (c) begin
        m_t = 1; m_n = clamp(nt); m_band = 0;
      end else begin
        m_act = 0; m_t = 0;
      end
    end else begin
      m_t++;
      if (m_t == run_len()) m_band = 1;
    end
  endtask

  // Check the cycle in progress, then drive the inputs sampled at its closing edge.
  task automatic cyc(input string tag, input bit s, input bit a, input bit c, input int nt);
    @(negedge clk);
    chk(tag, dut_vec(), exp_vec());
    start     = s;
    abort     = a;
    cont_mode = c;
    n_terms   = nt[CONST_W-1:0];
    model_step(s, a, c, nt);
  endtask

  task automatic single_run(input string tag, input int nt);
    cyc(tag, 1, 0, 0, nt);
    for (int i = 0; i < 10; i++) cyc(tag, 0, 0, 0, nt);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; abort = 0; cont_mode = 0; n_terms = '0;
    model_reset();
    #12;
    chk("reset", dut_vec(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc("idle", 0, 0, 0, 5);
    single_run("run5", 5);
    single_run("run3", 3);
    single_run("run0", 0);
    single_run("run7", 7);

    // Abort in the k = 3 RUN cycle, then a normal run.
    cyc("abort", 1, 0, 0, 5);
    for (int i = 0; i < 6; i++) cyc("abort", 0, m_act && m_t == 4, 0, 5);
    cyc("abort_idle", 1, 1, 0, 5);
    cyc("abort_idle", 0, 0, 0, 5);
    single_run("after_abort", 5);

    // Continuous mode with two terms.
    cyc("cont", 1, 0, 1, 2);
    for (int i = 0; i < 16; i++) cyc("cont", 0, 0, 1, 2);
    for (int i = 0; i < 8; i++) cyc("cont_stop", 0, 0, 0, 2);

    // Start re-asserted mid-run with a new count: must be ignored.
    cyc("restart", 1, 0, 0, 5);
    for (int i = 0; i < 10; i++) cyc("restart", m_t == 3, 0, 0, (m_t == 3) ? 1 : 5);

    // Asynchronous reset during the drain cycle.
    cyc("rst_mid", 1, 0, 0, 5);
    for (int i = 0; i < 20; i++) begin
      if (m_act && m_t == m_n + 2) break;
      cyc("rst_mid", 0, 0, 0, 5);
    end
    @(negedge clk);
    chk("drain", dut_vec(), exp_vec());
    #2 rst_n = 1'b0;
    #1 chk("async_rst", dut_vec(), 32'd0);
    model_reset();
    @(negedge clk);
    chk("rst_hold", dut_vec(), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc("post_rst", 0, 0, 0, 5);
    single_run("post_rst_run", 4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      cyc("rand", ($urandom % 4) == 0, ($urandom % 20) == 0, ($urandom % 3) == 0,
          int'($urandom % 8));
    @(negedge clk);
    chk("final", dut_vec(), exp_vec());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
